// File: rtl/subtractor_pkg.sv
// rtl/subtractor_pkg.sv - shared state encoding and default width for the serial subtractor
package subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - request/result bundle between a client and the serial subtractor
interface serial_subtractor_if
  import subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output start, a_in, b_in, bin,
    input  busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, a_in, b_in, bin,
    output busy, done, diff, bout, ovf
  );
endinterface

// File: rtl/fullsubtractor.sv
// rtl/fullsubtractor.sv - one-bit full subtractor cell computing a - b - c
module fullsubtractor (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic d,
  output logic bo
);
  assign d  = a ^ b ^ c;
  assign bo = (~a & b) | (~a & c) | (b & c);
endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial two's-complement subtractor, LSB first, one bit per clock
module serial_subtractor
  import subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_subtractor_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] diff_sr_q, diff_sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             brw_q, brw_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             cell_d, cell_bo;

  fullsubtractor u_cell (
    .a  (a_sr_q[0]),
    .b  (b_sr_q[0]),
    .c  (brw_q),
    .d  (cell_d),
    .bo (cell_bo)
  );

  always_comb begin
    state_d   = state_q;
    a_sr_d    = a_sr_q;
    b_sr_d    = b_sr_q;
    diff_sr_d = diff_sr_q;
    cnt_d     = cnt_q;
    brw_d     = brw_q;
    a_msb_d   = a_msb_q;
    b_msb_d   = b_msb_q;
    diff_d    = diff_q;
    bout_d    = bout_q;
    ovf_d     = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sr_d  = bus.a_in;
          b_sr_d  = bus.b_in;
          brw_d   = bus.bin;
          a_msb_d = bus.a_in[WIDTH-1];
          b_msb_d = bus.b_in[WIDTH-1];
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        diff_sr_d = {cell_d, diff_sr_q[WIDTH-1:1]};
        brw_d     = cell_bo;
        a_sr_d    = a_sr_q >> 1;
        b_sr_d    = b_sr_q >> 1;
        cnt_d     = cnt_q + CW'(1);
        // Results land only on the last bit so they stay stable through a later run
        if (cnt_q == LAST_BIT) begin
          diff_d  = {cell_d, diff_sr_q[WIDTH-1:1]};
          bout_d  = cell_bo;
          ovf_d   = (a_msb_q != b_msb_q) & (cell_d != a_msb_q);
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_sr_q    <= '0;
      b_sr_q    <= '0;
      diff_sr_q <= '0;
      cnt_q     <= '0;
      brw_q     <= 1'b0;
      a_msb_q   <= 1'b0;
      b_msb_q   <= 1'b0;
      diff_q    <= '0;
      bout_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_sr_q    <= a_sr_d;
      b_sr_q    <= b_sr_d;
      diff_sr_q <= diff_sr_d;
      cnt_q     <= cnt_d;
      brw_q     <= brw_d;
      a_msb_q   <= a_msb_d;
      b_msb_q   <= b_msb_d;
      diff_q    <= diff_d;
      bout_q    <= bout_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor against an arithmetic reference
module tb_serial_subtractor;
  localparam int W = 8;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t held;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic bin, input int when);
    exp_t e;
    int u;
    int s;
    u = int'(a) - int'(b) - int'(bin);
    s = int'($signed(a)) - int'($signed(b)) - int'(bin);
    e.diff = u[W-1:0];
    e.bout = (u < 0);
    e.ovf  = (s < -(2 ** (W - 1))) || (s > (2 ** (W - 1)) - 1);
    e.cyc  = when;
    return e;
  endfunction

  // Monitor: pops one expectation per done pulse; between pulses outputs must hold
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.done) begin
        chk("busy_with_done", {31'd0, bus.busy}, 32'd0);
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          held = sb.pop_front();
          chk("diff", {24'd0, bus.diff}, {24'd0, held.diff});
          chk("bout", {31'd0, bus.bout}, {31'd0, held.bout});
          chk("ovf", {31'd0, bus.ovf}, {31'd0, held.ovf});
          chk("done_cycle", cyc, held.cyc);
        end
      end else begin
        chk("held_diff", {24'd0, bus.diff}, {24'd0, held.diff});
        chk("held_flags", {30'd0, bus.bout, bus.ovf}, {30'd0, held.bout, held.ovf});
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                       input bit accept, output int k);
    @(negedge clk);
    bus.a_in  = a;
    bus.b_in  = b;
    bus.bin   = bin;
    bus.start = 1'b1;
    k = cyc;
    if (accept) sb.push_back(model(a, b, bin, cyc + W + 1));
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done_cycle(input int k);
    while (cyc < k + W + 1) @(negedge clk);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    int k;
    issue(a, b, bin, 1'b1, k);
    wait_done_cycle(k);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, bus.done}, 32'd0);
    chk({tag, "_diff"}, {24'd0, bus.diff}, 32'd0);
    chk({tag, "_bout"}, {31'd0, bus.bout}, 32'd0);
    chk({tag, "_ovf"}, {31'd0, bus.ovf}, 32'd0);
  endtask

  initial begin
    int k;
    int k2;
    held = '{diff: '0, bout: 1'b0, ovf: 1'b0, cyc: 0};
    bus.start = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    bus.bin   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset");

    run_op(8'h5A, 8'h3C, 1'b0);
    run_op(8'h00, 8'h01, 1'b0);
    run_op(8'h10, 8'h0F, 1'b1);
    run_op(8'h80, 8'h01, 1'b0);
    run_op(8'h7F, 8'hFF, 1'b0);
    run_op(8'h00, 8'h00, 1'b1);

    // Starts during RUN and during DONE must be dropped
    issue(8'h33, 8'h11, 1'b0, 1'b1, k);
    @(negedge clk);
    issue(8'hFF, 8'h77, 1'b1, 1'b0, k2);
    repeat (4) @(negedge clk);
    issue(8'hAA, 8'h55, 1'b1, 1'b0, k2);
    chk("ignored_start_timing", k2, k + W + 1);
    run_op(8'h01, 8'h02, 1'b0);

    // Reset in the middle of a run discards the operation
    issue(8'h44, 8'h22, 1'b0, 1'b1, k);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    sb.delete();
    held = '{diff: '0, bout: 1'b0, ovf: 1'b0, cyc: 0};
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrun_reset");
    run_op(8'h7F, 8'h80, 1'b1);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rbin;
      ra   = W'($urandom);
      rb   = W'($urandom);
      rbin = 1'($urandom);
      issue(ra, rb, rbin, 1'b1, k);
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(0, 5)) @(negedge clk);
        issue(W'($urandom), W'($urandom), 1'b0, 1'b0, k2);
      end
      wait_done_cycle(k);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    for (int t = 0; t < 50 && sb.size() > 0; t++) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
